// File: rtl/rb_write_arbiter.sv
// Register-bank write-port arbiter: one-entry holding register per result source
// (AR, T), round-robin grant, registered RB write outputs and a saturating conflict counter.
module rb_write_arbiter #(
   parameter int unsigned DW            = 32,
   parameter int unsigned AW            = 4,
   parameter int unsigned CW            = 8,
   parameter int unsigned ZERO_SUPPRESS = 0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          ar_valid,
   output logic          ar_ready,
   input  logic [AW-1:0] ar_dest,
   input  logic [DW-1:0] ar_data,
   input  logic          t_valid,
   output logic          t_ready,
   input  logic [AW-1:0] t_dest,
   input  logic [DW-1:0] t_data,
   input  logic          stall,
   input  logic          cnt_clr,
   output logic          rb_we,
   output logic [AW-1:0] rb_waddr,
   output logic [DW-1:0] rb_wdata,
   output logic          rb_sel,
   output logic [CW-1:0] conflict_cnt
);

   typedef enum logic {
      SRC_AR = 1'b0,
      SRC_T  = 1'b1
   } src_e;

   src_e          last_grant;
   logic          ar_h_v;
   logic [AW-1:0] ar_h_dest;
   logic [DW-1:0] ar_h_data;
   logic          t_h_v;
   logic [AW-1:0] t_h_dest;
   logic [DW-1:0] t_h_data;

   logic          grant_ar;
   logic          grant_t;
   logic          grant_any;
   logic          ar_acc;
   logic          t_acc;
   logic          conflict;
   logic          suppress;
   logic [AW-1:0] g_dest;
   logic [DW-1:0] g_data;

   always_comb begin
      grant_ar  = ar_h_v & ~stall & (~t_h_v | (last_grant == SRC_T));
      grant_t   = t_h_v & ~stall & (~ar_h_v | (last_grant == SRC_AR));
      grant_any = grant_ar | grant_t;
      g_dest    = grant_t ? t_h_dest : ar_h_dest;
      g_data    = grant_t ? t_h_data : ar_h_data;
      // register 0 may be consumed without a write strobe
      suppress  = (ZERO_SUPPRESS != 0) && (g_dest == '0);
      ar_ready  = ~ar_h_v | grant_ar;
      t_ready   = ~t_h_v | grant_t;
      ar_acc    = ar_valid & ar_ready;
      t_acc     = t_valid & t_ready;
      conflict  = ar_h_v & t_h_v & ~stall;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ar_h_v       <= 1'b0;
         t_h_v        <= 1'b0;
         last_grant   <= SRC_T;
         conflict_cnt <= '0;
         rb_we        <= 1'b0;
         rb_waddr     <= '0;
         rb_wdata     <= '0;
         rb_sel       <= 1'b0;
      end else begin
         // accept takes priority so a granted entry can be refilled on the same edge
         if (ar_acc) begin
            ar_h_v    <= 1'b1;
            ar_h_dest <= ar_dest;
            ar_h_data <= ar_data;
         end else if (grant_ar) begin
            ar_h_v <= 1'b0;
         end

         if (t_acc) begin
            t_h_v    <= 1'b1;
            t_h_dest <= t_dest;
            t_h_data <= t_data;
         end else if (grant_t) begin
            t_h_v <= 1'b0;
         end

         if (grant_any) begin
            rb_we      <= ~suppress;
            rb_waddr   <= g_dest;
            rb_wdata   <= g_data;
            rb_sel     <= grant_t;
            last_grant <= grant_t ? SRC_T : SRC_AR;
         end else begin
            rb_we <= 1'b0;
         end

         if (cnt_clr) begin
            conflict_cnt <= '0;
         end else if (conflict && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_rb_write_arbiter.sv
// Directed bench for rb_write_arbiter: a cycle table of inputs and hand-computed outputs,
// plus a long counter-saturation sequence. A second instance runs with zero suppression.
module tb_rb_write_arbiter;

   localparam logic [31:0] DB = 32'hDEAD_BEEF;
   localparam logic [31:0] A1 = 32'hA000_0001, A2 = 32'hA000_0002, A3 = 32'hA000_0003;
   localparam logic [31:0] B1 = 32'hB000_0001, B2 = 32'hB000_0002, B3 = 32'hB000_0003;
   localparam logic [31:0] C1 = 32'hC000_0001, D1 = 32'hD000_0001;
   localparam logic [31:0] E0 = 32'hE000_0000, E7 = 32'hE000_0007;
   localparam logic [31:0] F1 = 32'hF000_0001, F2 = 32'hF000_0002;

   logic        clk = 1'b0;
   logic        reset;
   logic        ar_valid, t_valid, stall, cnt_clr;
   logic [3:0]  ar_dest, t_dest;
   logic [31:0] ar_data, t_data;

   logic        ar_ready, t_ready, rb_we, rb_sel;
   logic [3:0]  rb_waddr;
   logic [31:0] rb_wdata;
   logic [7:0]  conflict_cnt;

   logic        z_ar_ready, z_t_ready, z_rb_we, z_rb_sel;
   logic [3:0]  z_rb_waddr;
   logic [31:0] z_rb_wdata;
   logic [7:0]  z_conflict_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rb_write_arbiter #(.DW(32), .AW(4), .CW(8), .ZERO_SUPPRESS(0)) dut (
      .clk(clk), .reset(reset),
      .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_dest(ar_dest), .ar_data(ar_data),
      .t_valid(t_valid), .t_ready(t_ready), .t_dest(t_dest), .t_data(t_data),
      .stall(stall), .cnt_clr(cnt_clr),
      .rb_we(rb_we), .rb_waddr(rb_waddr), .rb_wdata(rb_wdata), .rb_sel(rb_sel),
      .conflict_cnt(conflict_cnt)
   );

   rb_write_arbiter #(.DW(32), .AW(4), .CW(8), .ZERO_SUPPRESS(1)) dut_zs (
      .clk(clk), .reset(reset),
      .ar_valid(ar_valid), .ar_ready(z_ar_ready), .ar_dest(ar_dest), .ar_data(ar_data),
      .t_valid(t_valid), .t_ready(z_t_ready), .t_dest(t_dest), .t_data(t_data),
      .stall(stall), .cnt_clr(cnt_clr),
      .rb_we(z_rb_we), .rb_waddr(z_rb_waddr), .rb_wdata(z_rb_wdata), .rb_sel(z_rb_sel),
      .conflict_cnt(z_conflict_cnt)
   );

   typedef struct {
      logic        r, av;
      logic [3:0]  ad;
      logic [31:0] adat;
      logic        tv;
      logic [3:0]  td;
      logic [31:0] tdat;
      logic        st, clr;
      logic        e_ar, e_t, e_we;
      logic [3:0]  e_addr;
      logic [31:0] e_data;
      logic        e_sel;
      logic [7:0]  e_cnt;
      logic        e_zwe;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic r, input logic av, input logic [3:0] ad, input logic [31:0] adat,
                      input logic tv, input logic [3:0] td, input logic [31:0] tdat,
                      input logic st, input logic clr,
                      input logic e_ar, input logic e_t, input logic e_we, input logic [3:0] e_addr,
                      input logic [31:0] e_data, input logic e_sel, input logic [7:0] e_cnt,
                      input logic e_zwe);
      vec_t v;
      v.r = r; v.av = av; v.ad = ad; v.adat = adat; v.tv = tv; v.td = td; v.tdat = tdat;
      v.st = st; v.clr = clr; v.e_ar = e_ar; v.e_t = e_t; v.e_we = e_we; v.e_addr = e_addr;
      v.e_data = e_data; v.e_sel = e_sel; v.e_cnt = e_cnt; v.e_zwe = e_zwe;
      vq.push_back(v);
   endtask

   task automatic idle(input logic r, input logic st, input logic e_ar, input logic e_t,
                       input logic e_we, input logic [3:0] e_addr, input logic [31:0] e_data,
                       input logic e_sel, input logic [7:0] e_cnt, input logic e_zwe);
      add(r, 0, 0, 0, 0, 0, 0, st, 0, e_ar, e_t, e_we, e_addr, e_data, e_sel, e_cnt, e_zwe);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   initial begin
      // AR single write after reset
      add(0, 1, 5, DB,  0, 0, 0,   0, 0,  1, 1, 0, 0, 0, 0, 0, 0);
      idle(0, 0,  1, 1, 0, 0, 0,  0, 0, 0);
      idle(0, 0,  1, 1, 1, 5, DB, 0, 0, 1);
      idle(0, 0,  1, 1, 0, 5, DB, 0, 0, 0);
      // reset, then simultaneous same-dest accept: AR wins first
      idle(1, 0,  1, 1, 0, 5, DB, 0, 0, 0);
      add(0, 1, 3, 32'h11,  1, 3, 32'h22,  0, 0,  1, 1, 0, 0, 0, 0, 0, 0);
      idle(0, 0,  1, 0, 0, 0, 0,      0, 0, 0);
      idle(0, 0,  1, 1, 1, 3, 32'h11, 0, 1, 1);
      idle(0, 0,  1, 1, 1, 3, 32'h22, 1, 1, 1);
      idle(0, 0,  1, 1, 0, 3, 32'h22, 1, 1, 0);
      // continuous dual traffic: alternating grants, readies toggle
      add(0, 1, 1, A1,  1, 2, B1,  0, 0,  1, 1, 0, 3, 32'h22, 1, 1, 0);
      add(0, 1, 1, A2,  1, 2, B1,  0, 0,  1, 0, 0, 3, 32'h22, 1, 1, 0);
      add(0, 1, 1, A2,  1, 2, B2,  0, 0,  0, 1, 1, 1, A1, 0, 2, 1);
      add(0, 1, 1, A3,  1, 2, B2,  0, 0,  1, 0, 1, 2, B1, 1, 3, 1);
      add(0, 1, 1, A3,  1, 2, B3,  0, 0,  0, 1, 1, 1, A2, 0, 4, 1);
      idle(0, 0,  1, 0, 1, 2, B2, 1, 5, 1);
      idle(0, 0,  1, 1, 1, 1, A3, 0, 6, 1);
      idle(0, 0,  1, 1, 1, 2, B3, 1, 6, 1);
      // stall with both held, then resume opposite last_grant
      add(0, 1, 4, C1,  1, 6, D1,  0, 0,  1, 1, 0, 2, B3, 1, 6, 0);
      idle(0, 1,  0, 0, 0, 2, B3, 1, 6, 0);
      idle(0, 1,  0, 0, 0, 2, B3, 1, 6, 0);
      idle(0, 1,  0, 0, 0, 2, B3, 1, 6, 0);
      idle(0, 0,  1, 0, 0, 2, B3, 1, 6, 0);
      idle(0, 0,  1, 1, 1, 4, C1, 0, 7, 1);
      idle(0, 1,  1, 1, 1, 6, D1, 1, 7, 1);
      idle(0, 0,  1, 1, 0, 6, D1, 1, 7, 0);
      // T writes to dest 0 then dest 7 (second instance suppresses dest 0)
      add(0, 0, 0, 0,  1, 0, E0,  0, 0,  1, 1, 0, 6, D1, 1, 7, 0);
      add(0, 0, 0, 0,  1, 7, E7,  0, 0,  1, 1, 0, 6, D1, 1, 7, 0);
      idle(0, 0,  1, 1, 1, 0, E0, 1, 7, 0);
      idle(0, 0,  1, 1, 1, 7, E7, 1, 7, 1);
      idle(0, 0,  1, 1, 0, 7, E7, 1, 7, 0);
      // reset while both entries held: they are dropped
      add(0, 1, 8, F1,  1, 9, F2,  0, 0,  1, 1, 0, 7, E7, 1, 7, 0);
      idle(1, 0,  1, 0, 0, 7, E7, 1, 7, 0);
      idle(0, 0,  1, 1, 0, 0, 0,  0, 0, 0);
      idle(0, 0,  1, 1, 0, 0, 0,  0, 0, 0);

      reset = 1'b1; ar_valid = 0; t_valid = 0; ar_dest = 0; t_dest = 0;
      ar_data = 0; t_data = 0; stall = 0; cnt_clr = 0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("reset rb_we", 32'(rb_we), 0);
      chk("reset rb_waddr", 32'(rb_waddr), 0);
      chk("reset rb_wdata", rb_wdata, 0);
      chk("reset rb_sel", 32'(rb_sel), 0);
      chk("reset conflict_cnt", 32'(conflict_cnt), 0);
      chk("reset ar_ready", 32'(ar_ready), 1);
      chk("reset t_ready", 32'(t_ready), 1);

      for (int i = 0; i < vq.size(); i++) begin
         @(negedge clk);
         reset = vq[i].r; ar_valid = vq[i].av; ar_dest = vq[i].ad; ar_data = vq[i].adat;
         t_valid = vq[i].tv; t_dest = vq[i].td; t_data = vq[i].tdat;
         stall = vq[i].st; cnt_clr = vq[i].clr;
         #1;
         chk($sformatf("row%0d ar_ready", i), 32'(ar_ready), 32'(vq[i].e_ar));
         chk($sformatf("row%0d t_ready", i), 32'(t_ready), 32'(vq[i].e_t));
         chk($sformatf("row%0d rb_we", i), 32'(rb_we), 32'(vq[i].e_we));
         chk($sformatf("row%0d rb_waddr", i), 32'(rb_waddr), 32'(vq[i].e_addr));
         chk($sformatf("row%0d rb_wdata", i), rb_wdata, vq[i].e_data);
         chk($sformatf("row%0d rb_sel", i), 32'(rb_sel), 32'(vq[i].e_sel));
         chk($sformatf("row%0d conflict_cnt", i), 32'(conflict_cnt), 32'(vq[i].e_cnt));
         chk($sformatf("row%0d zs rb_we", i), 32'(z_rb_we), 32'(vq[i].e_zwe));
      end

      // Counter saturation: both sources always valid keeps both entries held every cycle
      reset = 0; stall = 0; cnt_clr = 0;
      ar_valid = 1; ar_dest = 1; ar_data = A1;
      t_valid = 1;  t_dest = 2;  t_data = B1;
      repeat (101) @(negedge clk);
      #1;
      chk("sat cnt after 100 conflicts", 32'(conflict_cnt), 100);
      chk("sat rb_we sustained", 32'(rb_we), 1);
      repeat (200) @(negedge clk);
      #1;
      chk("sat cnt saturated", 32'(conflict_cnt), 255);
      chk("sat zs cnt saturated", 32'(z_conflict_cnt), 255);
      cnt_clr = 1;
      @(negedge clk);
      #1;
      chk("sat cnt_clr beats increment", 32'(conflict_cnt), 0);
      cnt_clr = 0; ar_valid = 0; t_valid = 0;
      @(negedge clk);
      #1;
      chk("sat cnt restarts", 32'(conflict_cnt), 1);
      repeat (4) @(negedge clk);
      #1;
      chk("drain rb_we", 32'(rb_we), 0);
      chk("drain ar_ready", 32'(ar_ready), 1);
      chk("drain t_ready", 32'(t_ready), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rb_write_arbiter.md
Name: rb_write_arbiter

Overview:
- Schedules the single register-bank (RB) write port between the AR-type result path and the T-type result path.
- Each source gets a one-entry holding register behind a valid/ready handshake.
- Each cycle the block grants one held entry and drives registered write-enable, destination, data and the select line for the 4-bit dest-reg and 32-bit constant/data 2:1 muxes in front of RB.
- Conflicts are resolved round-robin and counted.

Parameters:
DW, 32, data width of both result paths and RB write data
AW, 4, RB address (dest register) width
CW, 8, width of saturating conflict counter
ZERO_SUPPRESS, 0, when 1 a write to register 0 is consumed but never asserted on rb_we

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous active-high reset
ar_valid  in  1  AR-type result available
ar_ready  out  1  AR entry accepted this cycle when ar_valid&ar_ready
ar_dest  in  AW  AR destination register
ar_data  in  DW  AR result
t_valid  in  1  T-type result available
t_ready  out  1  T entry accepted when t_valid&t_ready
t_dest  in  AW  T destination register
t_data  in  DW  T constant/transfer value
stall  in  1  RB port unavailable; no grant this cycle
cnt_clr  in  1  clears conflict_cnt
rb_we  out  1  registered RB write enable
rb_waddr  out  AW  registered RB write address
rb_wdata  out  DW  registered RB write data
rb_sel  out  1  registered mux select, 0=AR source, 1=T source
conflict_cnt  out  CW  cycles where both entries were held and grantable

Behaviour:
- State: ar_h_v/ar_h_dest/ar_h_data, t_h_v/t_h_dest/t_h_data, last_grant (0=AR, 1=T), conflict_cnt, output registers.
- Reset (synchronous, dominates all inputs):
  - Holding regs are invalidated; rb_we=0, rb_waddr=0, rb_wdata=0, rb_sel=0.
  - last_grant=1, so AR wins the first conflict; conflict_cnt=0.
  - Pending entries are dropped, not written.
  - ar_ready/t_ready evaluate to 1 in the cycle after reset.
- Grant (combinational, within a cycle):
  - grant_ar = ar_h_v & !stall & (!t_h_v | last_grant==1)
  - grant_t = t_h_v & !stall & (!ar_h_v | last_grant==0)
  - At most one grant per cycle.
- Ready (pass-through, full throughput): ar_ready = !ar_h_v | grant_ar; t_ready = !t_h_v | grant_t.
- On each rising edge, not in reset:
  - Granted entry: its holding reg is cleared, unless refilled the same edge (accept & grant simultaneous → reg loads new entry, stays valid).
  - Output registers: rb_we <= grant_any & !(ZERO_SUPPRESS & granted_dest==0); rb_waddr/rb_wdata <= granted entry; rb_sel <= grant_t.
  - With no grant: rb_we <= 0; rb_waddr/rb_wdata/rb_sel hold their previous values.
  - last_grant <= grant_t when grant_any, else unchanged.
  - Counter: conflict_cnt <= 0 if cnt_clr; else +1 if ar_h_v & t_h_v & !stall, saturating at all-ones. cnt_clr wins over a simultaneous increment.
- Latency:
  - Entry accepted at edge E0 is granted in the following cycle if uncontested.
  - rb_we is high for exactly one cycle, starting at E1.
  - Sustained single-source throughput: one write per cycle.
- Same-dest conflict (ar_h_dest==t_h_dest): no special ordering; round-robin applies, so the loser writes one cycle later and its value is final in RB.
- stall: no grant, holding regs keep contents, readies = !held, rb_we deasserts at the next edge. Deasserting stall resumes with last_grant unchanged.
- Held entries never change until granted or reset; input data is sampled only on acceptance.

Test Plan:
- Reset, then AR single write: ar_valid=1, ar_dest=5, ar_data=0xDEADBEEF for one cycle → one cycle later rb_we=1, rb_waddr=5, rb_wdata=0xDEADBEEF, rb_sel=0; rb_we=0 after; conflict_cnt=0.
- Simultaneous accept after reset: AR(dest 3, 0x11) and T(dest 3, 0x22) same edge → writes AR 0x11 (sel 0) then T 0x22 (sel 1) on consecutive cycles; conflict_cnt=1.
- Continuous dual traffic for 6 cycles → rb_sel alternates 0,1,0,1,…; 6 writes, no drops; each source's ready toggles.
- stall=1 for 3 cycles with both entries held → rb_we=0, ar_ready=t_ready=0, conflict_cnt unchanged. Release → grant resumes with the source opposite last_grant.
- ZERO_SUPPRESS=1, T write to dest 0 then dest 7 → dest 0 is consumed with rb_we=0 and t_ready pulses; dest 7 is written next cycle.
- Reset asserted while both entries held → no rb_we afterward, holding regs empty, conflict_cnt=0. Drive conflict_cnt to 255 (CW=8) → stays 255; cnt_clr → 0.
